// File: rtl/mult_iter_if.sv
// Request/response bundle for the iterative multiplier.
//   master: issues signed_mul_i, a, b, start_i, annul_i; observes result_o, ready_o, busy_o
//   slave : the multiplier side of the same signals
interface mult_iter_if #(
  parameter int unsigned WIDTH = 32
);

  logic                   signed_mul_i;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   start_i;
  logic                   annul_i;
  logic [2*WIDTH-1:0]     result_o;
  logic                   ready_o;
  logic                   busy_o;

  modport master (
    output signed_mul_i, a, b, start_i, annul_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  signed_mul_i, a, b, start_i, annul_i,
    output result_o, ready_o, busy_o
  );

endinterface

// File: rtl/mult_iter.sv
// Iterative shift-add multiplier: one operand bit per cycle, sign handled by
// multiplying magnitudes and negating the 2*WIDTH-bit product at the end.
//   clk   : system clock, rising edge
//   rst   : asynchronous active-low reset
//   bus   : slave side of mult_iter_if (operands, start/annul, result, ready/busy)
module mult_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  mult_iter_if.slave  bus
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [PW-1:0]    prod;
  logic             neg;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    result_q;
  logic             ready_q;
  logic             busy_q;

  logic [WIDTH-1:0] a_abs_c;
  logic [WIDTH-1:0] b_abs_c;
  logic [WIDTH:0]   sum_c;
  logic [PW-1:0]    prod_next_c;
  logic [PW-1:0]    res_c;
  logic             last_iter_c;

  // Operand magnitudes; the most negative value maps to its unsigned magnitude.
  always_comb begin
    a_abs_c = bus.a;
    b_abs_c = bus.b;
    if (bus.signed_mul_i && bus.a[WIDTH-1]) a_abs_c = WIDTH'(~bus.a + WIDTH'(1));
    if (bus.signed_mul_i && bus.b[WIDTH-1]) b_abs_c = WIDTH'(~bus.b + WIDTH'(1));
  end

  // One shift-add step: carry-out of the upper-half add becomes the new MSB.
  always_comb begin
    sum_c       = {1'b0, prod[PW-1:WIDTH]};
    if (prod[0]) sum_c = sum_c + {1'b0, mcand};
    prod_next_c = {sum_c, prod[WIDTH-1:1]};
    res_c       = neg ? PW'(~prod_next_c + PW'(1)) : prod_next_c;
    last_iter_c = (cnt == CW'(WIDTH - 1));
  end

  // Control and datapath registers; ready/busy are registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      mcand    <= '0;
      prod     <= '0;
      neg      <= 1'b0;
      cnt      <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_i && !bus.annul_i) begin
            mcand  <= a_abs_c;
            prod   <= {{WIDTH{1'b0}}, b_abs_c};
            neg    <= bus.signed_mul_i & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            cnt    <= '0;
            state  <= CALC;
            busy_q <= 1'b1;
          end
        end
        CALC: begin
          if (bus.annul_i) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            prod <= prod_next_c;
            cnt  <= cnt + CW'(1);
            if (last_iter_c) begin
              state    <= DONE;
              result_q <= res_c;
              ready_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
  assign bus.busy_o   = busy_q;

endmodule

// File: doc/mult_iter.md
MULT_ITER -- requirements
Module: mult_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; the product is 2*WIDTH bits and one iteration runs per operand bit.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port signed_mul_i  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start_i.
REQ-005 SHALL have port a  input  WIDTH  multiplicand; sampled with start_i.
REQ-006 SHALL have port b  input  WIDTH  multiplier; sampled with start_i.
REQ-007 SHALL have port start_i  input  1  request a new multiply; honoured only in IDLE.
REQ-008 SHALL have port annul_i  input  1  abort the operation in progress.
REQ-009 SHALL have port result_o  output  2*WIDTH  product {HI,LO}; holds its last value until the next completion.
REQ-010 SHALL have port ready_o  output  1  one-cycle completion pulse; result_o is valid while it is high.
REQ-011 SHALL have port busy_o  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL implement states IDLE, CALC and DONE as a registered state machine.
REQ-013 IDLE: when start_i=1 and annul_i=0 at an edge, SHALL do all of the following and enter CALC:
- latch |a| as the multiplicand;
- load the product register as {WIDTH'b0, |b|};
- latch result sign = signed_mul_i & (a[MSB]^b[MSB]);
- clear the iteration counter.
REQ-014 Absolute value SHALL be taken only when signed_mul_i=1 and the operand MSB=1; otherwise the operand SHALL pass unchanged; |-2^(WIDTH-1)| SHALL be 2^(WIDTH-1) as an unsigned value.
REQ-015 CALC: each edge SHALL add the multiplicand to the upper half when the product LSB is 1, keep the carry-out as bit WIDTH, shift the (2*WIDTH+1)-bit sum right by one, and increment the counter.
REQ-016 After exactly WIDTH CALC iterations, the final edge SHALL enter DONE and load result_o, negated in two's complement across all 2*WIDTH bits if the latched sign is 1.
REQ-017 DONE SHALL assert ready_o for exactly one cycle, then return to IDLE on the next edge unconditionally.
REQ-018 Latency: ready_o SHALL be high in the cycle that follows the (WIDTH+1)th rising edge counted from the edge that samples start_i; 33 edges for WIDTH=32.
REQ-019 start_i SHALL be ignored in CALC and DONE; a start_i still high in the IDLE cycle after DONE SHALL launch a new operation (the consumer drops start_i on ready_o).
REQ-020 annul_i=1 in CALC or DONE SHALL force IDLE on the next edge, suppress ready_o from that edge onward, and leave result_o unchanged.
REQ-021 annul_i=1 together with start_i=1 in IDLE SHALL prevent the start: the block stays in IDLE.
REQ-022 A zero operand SHALL still take the full latency and SHALL produce result_o=0; the sign SHALL NOT turn a zero result negative.
REQ-023 ready_o and busy_o SHALL be decoded from registered state only, with no combinational path from any input.

Reset
REQ-024 rst=0 SHALL immediately force, regardless of clk:
- state = IDLE;
- result_o = 0;
- ready_o = 0, busy_o = 0;
- counter = 0;
- internal product, multiplicand and sign registers = 0.
REQ-025 Reset asserted mid-operation SHALL discard the operation; after rst returns to 1, no ready_o pulse SHALL occur until a new start_i.

Verification
REQ-026 Unsigned: signed_mul_i=0, a=b=0xFFFFFFFF, one-cycle start_i -> ready_o high in the cycle after edge 33 with result_o=0xFFFFFFFE_00000001; busy_o high during edges 1..33.
REQ-027 Signed: signed_mul_i=1, a=0xFFFFFFFD (-3), b=7 -> result_o=0xFFFFFFFF_FFFFFFEB (-21); then a=b=0x80000000 -> result_o=0x40000000_00000000.
REQ-028 Annul: start with a=5, b=6, then annul_i=1 at iteration 10 -> IDLE next edge, ready_o never asserts, result_o keeps its prior value; a following start_i with a=5, b=6 yields 30.
REQ-029 Held start: start_i held high through completion -> exactly one ready_o pulse, then a second operation begins in the IDLE cycle; start_i dropped on ready_o -> no second operation.
REQ-030 Reset mid-CALC: rst=0 at iteration 16 -> result_o=0, busy_o=0 immediately, and no ready_o after release.
REQ-031 Random: 10k random signed and unsigned operand pairs with random annul_i and random start_i gaps -> every ready_o result matches a 64-bit reference product.
